// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge
//   Uncached bridge from the CPU's SRAM-like instruction and data ports to a
//   single AXI3 master. Reads from both ports share one AR channel, with data
//   reads taking priority over fetches. Writes go out on AW/W/B one at a time.
//   At most one read and one write are outstanding at any time.
//
// Ports
//   clk, resetn                    clock, asynchronous active-low reset
//   inst_sram_*                    fetch request/response (read only)
//   data_sram_*                    data request/response (read or write)
//   ar*/r*                         AXI read address / read data channels
//   aw*/w*/b*                      AXI write address / data / response channels
//
// Read FSM
//   state  | meaning
//   R_IDLE | no read outstanding, may accept a data read or a fetch
//   R_AR   | arvalid asserted, waiting for arready
//   R_R    | rready asserted, waiting for rvalid
//
// Write FSM
//   state  | meaning
//   W_IDLE | no write outstanding, may accept a data write
//   W_REQ  | AW and W handshakes in progress (either order, or together)
//   W_B    | bready asserted, waiting for bvalid

module sram_axi_bridge (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_t;

    r_state_t    r_state_q, r_state_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [1:0]  ar_size_q, ar_size_d;
    logic        ar_is_data_q, ar_is_data_d;

    w_state_t    w_state_q, w_state_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [1:0]  aw_size_q, aw_size_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic [31:0] w_data_q, w_data_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic data_rd_req;
    logic data_wr_req;
    logic data_rd_busy;
    logic data_rd_acc;
    logic data_wr_acc;
    logic inst_acc;
    logic data_rd_ok;
    logic data_wr_ok;
    logic aw_hs;
    logic w_hs;
    logic unused_inputs;

    // Response fields the bridge does not act on.
    assign unused_inputs = ^{rresp, rlast, bid, bresp};

    assign data_rd_req  = data_sram_req & ~data_sram_wr;
    assign data_wr_req  = data_sram_req &  data_sram_wr;
    assign data_rd_busy = (r_state_q != R_IDLE) & ar_is_data_q;

    // Acceptance is gated by resetn so no *_ok can rise while reset is held,
    // even though both FSMs already sit in IDLE.
    // A pending data read is the read-side winner even when it is blocked by
    // an outstanding write, so a fetch never slips past it.
    assign data_rd_acc = resetn & (r_state_q == R_IDLE) & (w_state_q == W_IDLE) & data_rd_req;
    assign inst_acc    = resetn & (r_state_q == R_IDLE) & inst_sram_req & ~data_rd_req;
    assign data_wr_acc = resetn & (w_state_q == W_IDLE) & ~data_rd_busy & data_wr_req;

    assign inst_sram_addr_ok = inst_acc;
    assign data_sram_addr_ok = data_rd_acc | data_wr_acc;
    assign data_sram_data_ok = data_rd_ok | data_wr_ok;

    assign inst_sram_rdata = rdata;
    assign data_sram_rdata = rdata;

    assign arid    = {3'b000, ar_is_data_q};
    assign araddr  = ar_addr_q;
    assign arsize  = {1'b0, ar_size_q};
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign awid    = 4'd1;
    assign awaddr  = aw_addr_q;
    assign awsize  = {1'b0, aw_size_q};
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    assign wid   = 4'd1;
    assign wdata = w_data_q;
    assign wstrb = w_strb_q;
    assign wlast = 1'b1;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q    <= R_IDLE;
            ar_addr_q    <= 32'd0;
            ar_size_q    <= 2'd0;
            ar_is_data_q <= 1'b0;
        end else begin
            r_state_q    <= r_state_d;
            ar_addr_q    <= ar_addr_d;
            ar_size_q    <= ar_size_d;
            ar_is_data_q <= ar_is_data_d;
        end
    end

    always_comb begin
        r_state_d         = r_state_q;
        ar_addr_d         = ar_addr_q;
        ar_size_d         = ar_size_q;
        ar_is_data_d      = ar_is_data_q;
        arvalid           = 1'b0;
        rready            = 1'b0;
        inst_sram_data_ok = 1'b0;
        data_rd_ok        = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (data_rd_acc) begin
                    ar_addr_d    = data_sram_addr;
                    ar_size_d    = data_sram_size;
                    ar_is_data_d = 1'b1;
                    r_state_d    = R_AR;
                end else if (inst_acc) begin
                    ar_addr_d    = inst_sram_addr;
                    ar_size_d    = inst_sram_size;
                    ar_is_data_d = 1'b0;
                    r_state_d    = R_AR;
                end
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    r_state_d = R_R;
                end
            end
            R_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    inst_sram_data_ok = (rid == 4'd0);
                    data_rd_ok        = (rid == 4'd1);
                    r_state_d         = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_q <= W_IDLE;
            aw_addr_q <= 32'd0;
            aw_size_q <= 2'd0;
            w_strb_q  <= 4'd0;
            w_data_q  <= 32'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            aw_addr_q <= aw_addr_d;
            aw_size_q <= aw_size_d;
            w_strb_q  <= w_strb_d;
            w_data_q  <= w_data_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        w_state_d  = w_state_q;
        aw_addr_d  = aw_addr_q;
        aw_size_d  = aw_size_q;
        w_strb_d   = w_strb_q;
        w_data_d   = w_data_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        data_wr_ok = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (data_wr_acc) begin
                    aw_addr_d = data_sram_addr;
                    aw_size_d = data_sram_size;
                    w_strb_d  = data_sram_wstrb;
                    w_data_d  = data_sram_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_REQ;
                end
            end
            W_REQ: begin
                awvalid = ~aw_done_q;
                wvalid  = ~w_done_q;
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                // Both channels finished, whether now or in earlier cycles.
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                    w_state_d = W_B;
                end
            end
            W_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_wr_ok = 1'b1;
                    w_state_d  = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
module tb_sram_axi_bridge;

    logic        clk;
    logic        resetn;
    logic        inst_sram_req;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_chk;
    int n_pass;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size),
        .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        resetn = 1'b0;
        inst_sram_req = 1'b0; inst_sram_size = 2'd0; inst_sram_addr = 32'd0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0;
        data_sram_wstrb = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'd0; bvalid = 1'b0;

        // Reset state
        cyc(); cyc();
        #1;
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_awvalid", {31'd0, awvalid}, 32'd0);
        check("rst_wvalid",  {31'd0, wvalid},  32'd0);
        check("rst_rready",  {31'd0, rready},  32'd0);
        check("rst_bready",  {31'd0, bready},  32'd0);
        check("rst_araddr",  araddr, 32'd0);
        check("rst_awaddr",  awaddr, 32'd0);
        check("const_ar", {arlen, 6'd0, arburst, 2'd0, arlock, arcache, arprot, 1'b0}, {8'd0, 6'd0, 2'b01, 2'd0, 2'b00, 4'd0, 3'd0, 1'b0});
        check("const_w",  {awid, wid, 3'd0, wlast, awlen}, {4'd1, 4'd1, 3'd0, 1'b1, 8'd0});
        cyc();
        resetn = 1'b1;

        // Test 1: single fetch, arready immediate, rvalid next cycle
        cyc();
        inst_sram_req = 1'b1; inst_sram_size = 2'd2; inst_sram_addr = 32'h1C00_0000;
        #1;
        check("t1_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        cyc();
        inst_sram_req = 1'b0; arready = 1'b1;
        #1;
        check("t1_arvalid", {31'd0, arvalid}, 32'd1);
        check("t1_araddr",  araddr, 32'h1C00_0000);
        check("t1_arid",    {28'd0, arid}, 32'd0);
        check("t1_arsize",  {29'd0, arsize}, 32'd2);
        check("t1_inst_addr_ok_low", {31'd0, inst_sram_addr_ok}, 32'd0);
        cyc();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h0280_0C0C;
        #1;
        check("t1_rready",       {31'd0, rready}, 32'd1);
        check("t1_inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
        check("t1_inst_rdata",   inst_sram_rdata, 32'h0280_0C0C);
        check("t1_data_data_ok", {31'd0, data_sram_data_ok}, 32'd0);
        cyc();
        rvalid = 1'b0;
        #1;
        check("t1_data_ok_pulse", {31'd0, inst_sram_data_ok}, 32'd0);
        check("t1_idle_arvalid",  {31'd0, arvalid}, 32'd0);
        check("t1_idle_rready",   {31'd0, rready}, 32'd0);

        // Test 2: simultaneous inst and data reads, data wins
        cyc();
        inst_sram_req = 1'b1; inst_sram_size = 2'd2; inst_sram_addr = 32'h1C00_0004;
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_size = 2'd2; data_sram_addr = 32'h8000_0020;
        #1;
        check("t2_data_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
        check("t2_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
        cyc();
        data_sram_req = 1'b0; arready = 1'b1;
        #1;
        check("t2_arid",   {28'd0, arid}, 32'd1);
        check("t2_araddr", araddr, 32'h8000_0020);
        check("t2_inst_wait_ar", {31'd0, inst_sram_addr_ok}, 32'd0);
        cyc();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'hDEAD_BEEF;
        #1;
        check("t2_data_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
        check("t2_data_rdata",   data_sram_rdata, 32'hDEAD_BEEF);
        check("t2_inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
        check("t2_inst_wait_r",  {31'd0, inst_sram_addr_ok}, 32'd0);
        cyc();
        rvalid = 1'b0;
        #1;
        check("t2_inst_accept", {31'd0, inst_sram_addr_ok}, 32'd1);
        cyc();
        inst_sram_req = 1'b0; arready = 1'b1;
        #1;
        check("t2_inst_arid",   {28'd0, arid}, 32'd0);
        check("t2_inst_araddr", araddr, 32'h1C00_0004);
        cyc();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_1111;
        #1;
        check("t2_inst_done", {31'd0, inst_sram_data_ok}, 32'd1);
        cyc();
        rvalid = 1'b0;

        // Test 3: write, wready three cycles after awready
        cyc();
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'd2;
        data_sram_addr = 32'h8000_0010; data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h1122_3344;
        #1;
        check("t3_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
        cyc();
        data_sram_req = 1'b0; awready = 1'b1;
        #1;
        check("t3_awvalid", {31'd0, awvalid}, 32'd1);
        check("t3_wvalid",  {31'd0, wvalid},  32'd1);
        check("t3_awaddr",  awaddr, 32'h8000_0010);
        check("t3_awsize",  {29'd0, awsize}, 32'd2);
        check("t3_wstrb",   {28'd0, wstrb}, 32'h3);
        check("t3_wdata",   wdata, 32'h1122_3344);
        for (int i = 0; i < 2; i++) begin
            cyc();
            awready = 1'b0;
            #1;
            check("t3_aw_dropped", {31'd0, awvalid}, 32'd0);
            check("t3_w_held",     {31'd0, wvalid},  32'd1);
        end
        cyc();
        wready = 1'b1;
        #1;
        check("t3_w_hs", {31'd0, wvalid}, 32'd1);
        cyc();
        wready = 1'b0;
        #1;
        check("t3_wvalid_low", {31'd0, wvalid}, 32'd0);
        check("t3_bready",     {31'd0, bready}, 32'd1);
        check("t3_no_early_ok", {31'd0, data_sram_data_ok}, 32'd0);
        cyc();
        bvalid = 1'b1;
        #1;
        check("t3_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
        cyc();
        bvalid = 1'b0;
        #1;
        check("t3_ok_pulse", {31'd0, data_sram_data_ok}, 32'd0);
        check("t3_bready_low", {31'd0, bready}, 32'd0);

        // Test 4: fetch overlaps an outstanding write; second write is held
        cyc();
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h8000_0040;
        data_sram_wstrb = 4'hF; data_sram_wdata = 32'hCAFE_F00D;
        #1;
        check("t4_wr1_accept", {31'd0, data_sram_addr_ok}, 32'd1);
        cyc();
        data_sram_addr = 32'h8000_0044; data_sram_wdata = 32'h5555_AAAA;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0008;
        #1;
        check("t4_inst_accept", {31'd0, inst_sram_addr_ok}, 32'd1);
        check("t4_wr2_held_a",  {31'd0, data_sram_addr_ok}, 32'd0);
        cyc();
        inst_sram_req = 1'b0; arready = 1'b1;
        #1;
        check("t4_inst_arvalid", {31'd0, arvalid}, 32'd1);
        check("t4_inst_arid",    {28'd0, arid}, 32'd0);
        cyc();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h1234_5678;
        #1;
        check("t4_inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
        check("t4_no_data_ok",   {31'd0, data_sram_data_ok}, 32'd0);
        check("t4_wr2_held_b",   {31'd0, data_sram_addr_ok}, 32'd0);
        cyc();
        rvalid = 1'b0; awready = 1'b1; wready = 1'b1;
        #1;
        check("t4_aw_w_both", {30'd0, awvalid, wvalid}, 32'd3);
        check("t4_awaddr1",   awaddr, 32'h8000_0040);
        cyc();
        awready = 1'b0; wready = 1'b0;
        #1;
        check("t4_bready",     {31'd0, bready}, 32'd1);
        check("t4_wr2_held_c", {31'd0, data_sram_addr_ok}, 32'd0);
        cyc();
        bvalid = 1'b1;
        #1;
        check("t4_wr1_done",   {31'd0, data_sram_data_ok}, 32'd1);
        check("t4_wr2_held_d", {31'd0, data_sram_addr_ok}, 32'd0);
        cyc();
        bvalid = 1'b0;
        #1;
        check("t4_wr2_accept", {31'd0, data_sram_addr_ok}, 32'd1);
        cyc();
        data_sram_req = 1'b0; awready = 1'b1; wready = 1'b1;
        #1;
        check("t4_awaddr2", awaddr, 32'h8000_0044);
        check("t4_wdata2",  wdata, 32'h5555_AAAA);
        cyc();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        #1;
        check("t4_wr2_done", {31'd0, data_sram_data_ok}, 32'd1);
        cyc();
        bvalid = 1'b0;

        // Test 5: arready held low five cycles
        cyc();
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_size = 2'd1; data_sram_addr = 32'h8000_0082;
        #1;
        check("t5_accept", {31'd0, data_sram_addr_ok}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            data_sram_req = 1'b0;
            #1;
            check("t5_ar_stable", {arvalid, arid, arsize, 24'd0}, {1'b1, 4'd1, 3'd1, 24'd0});
            check("t5_araddr_stable", araddr, 32'h8000_0082);
        end
        cyc();
        arready = 1'b1;
        #1;
        check("t5_ar_hs", {31'd0, arvalid}, 32'd1);
        cyc();
        arready = 1'b0;
        #1;
        check("t5_no_dup_ar", {31'd0, arvalid}, 32'd0);
        check("t5_rready",    {31'd0, rready},  32'd1);
        cyc();
        rvalid = 1'b1; rid = 4'd1; rdata = 32'h0000_BEEF;
        #1;
        check("t5_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
        cyc();
        rvalid = 1'b0;

        // Test 6: reset during R_R and W_REQ
        cyc();
        inst_sram_req = 1'b1; inst_sram_size = 2'd2; inst_sram_addr = 32'h1C00_0010;
        #1;
        check("t6_inst_accept", {31'd0, inst_sram_addr_ok}, 32'd1);
        cyc();
        inst_sram_req = 1'b0; arready = 1'b1;
        cyc();
        arready = 1'b0;
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h8000_0100;
        data_sram_wstrb = 4'hF; data_sram_wdata = 32'h0BAD_F00D;
        #1;
        check("t6_wr_accept", {31'd0, data_sram_addr_ok}, 32'd1);
        check("t6_in_rr",     {31'd0, rready}, 32'd1);
        cyc();
        data_sram_req = 1'b0;
        #1;
        check("t6_in_wreq", {30'd0, awvalid, rready}, 32'd3);
        #1;
        resetn = 1'b0;
        inst_sram_req = 1'b1; data_sram_req = 1'b1; data_sram_wr = 1'b0;
        #1;
        check("t6_rst_handshakes", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        check("t6_rst_oks", {28'd0, inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok}, 32'd0);
        check("t6_rst_regs", araddr | awaddr | wdata, 32'd0);
        cyc();
        #1;
        check("t6_rst_held_oks", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd0);
        cyc();
        resetn = 1'b1; data_sram_req = 1'b0;
        inst_sram_addr = 32'h1C00_0020;
        #1;
        check("t6_post_accept", {31'd0, inst_sram_addr_ok}, 32'd1);
        cyc();
        inst_sram_req = 1'b0; arready = 1'b1;
        #1;
        check("t6_post_araddr", araddr, 32'h1C00_0020);
        cyc();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'hA5A5_0001;
        #1;
        check("t6_post_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
        check("t6_post_rdata",   inst_sram_rdata, 32'hA5A5_0001);
        cyc();
        rvalid = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
